// File: rtl/core_exec_sequencer.sv
// Sequences the shared ALU for each issued instruction: plain ALU ops, two-step
// branches (compare, then target add) and load/store address generation plus memory handshake.
module core_exec_sequencer #(
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned ALU_OP_WIDTH   = 4,
  parameter int unsigned ALU_OP_ADD     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [ALU_OP_WIDTH-1:0]   issue_alu_op,
  input  logic [REG_DATA_WIDTH-1:0] issue_s1,
  input  logic [REG_DATA_WIDTH-1:0] issue_s2,
  input  logic [REG_DATA_WIDTH-1:0] issue_imm,
  input  logic [REG_DATA_WIDTH-1:0] issue_pc,
  input  logic                      issue_is_branch,
  input  logic                      issue_is_loadstore,
  input  logic                      issue_is_store,
  input  logic                      flush,
  output logic [ALU_OP_WIDTH-1:0]   alu_op,
  output logic [REG_DATA_WIDTH-1:0] alu_s1,
  output logic [REG_DATA_WIDTH-1:0] alu_s2,
  input  logic [REG_DATA_WIDTH-1:0] alu_d,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [REG_DATA_WIDTH-1:0] mem_req_addr,
  output logic [REG_DATA_WIDTH-1:0] mem_req_wdata,
  output logic                      mem_req_we,
  input  logic                      mem_rsp_valid,
  input  logic [REG_DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic                      wb_valid,
  output logic [REG_DATA_WIDTH-1:0] wb_data,
  output logic                      br_valid,
  output logic                      br_taken,
  output logic [REG_DATA_WIDTH-1:0] br_target
);

  typedef enum logic [2:0] {IDLE, EXEC, BR_TGT, MEM_REQ, MEM_RSP} state_e;

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = ALU_OP_WIDTH'(ALU_OP_ADD);

  state_e                    state_q, state_d;
  logic [ALU_OP_WIDTH-1:0]   op_q, op_d;
  logic [REG_DATA_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, imm_q, imm_d, pc_q, pc_d;
  logic                      is_br_q, is_br_d, is_ls_q, is_ls_d, is_st_q, is_st_d;
  logic                      kill_q, kill_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                      br_valid_q, br_valid_d, br_taken_q, br_taken_d;
  logic [REG_DATA_WIDTH-1:0] br_target_q, br_target_d;
  logic [REG_DATA_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [REG_DATA_WIDTH-1:0] mem_req_wdata_q, mem_req_wdata_d;
  logic                      mem_req_we_q, mem_req_we_d;

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    s1_d            = s1_q;
    s2_d            = s2_q;
    imm_d           = imm_q;
    pc_d            = pc_q;
    is_br_d         = is_br_q;
    is_ls_d         = is_ls_q;
    is_st_d         = is_st_q;
    kill_d          = kill_q;
    wb_valid_d      = 1'b0;
    wb_data_d       = wb_data_q;
    br_valid_d      = 1'b0;
    br_taken_d      = br_taken_q;
    br_target_d     = br_target_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    mem_req_we_d    = mem_req_we_q;
    issue_ready     = 1'b0;
    alu_op          = '0;
    alu_s1          = '0;
    alu_s2          = '0;
    mem_req_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A flush in IDLE blocks the handshake rather than accepting and dropping.
        issue_ready = rst_n & ~flush;
        if (issue_valid && issue_ready) begin
          op_d    = issue_alu_op;
          s1_d    = issue_s1;
          s2_d    = issue_s2;
          imm_d   = issue_imm;
          pc_d    = issue_pc;
          is_br_d = issue_is_branch;
          is_ls_d = issue_is_loadstore;
          is_st_d = issue_is_store;
          kill_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_br_q) begin
          alu_op = op_q;
          alu_s1 = s1_q;
          alu_s2 = s2_q;
          if (flush) begin
            state_d = IDLE;
          end else if (alu_d[0]) begin
            state_d = BR_TGT;
          end else begin
            br_valid_d  = 1'b1;
            br_taken_d  = 1'b0;
            br_target_d = '0;
            state_d     = IDLE;
          end
        end else if (is_ls_q) begin
          alu_op = OP_ADD;
          alu_s1 = s1_q;
          alu_s2 = imm_q;
          if (flush) begin
            state_d = IDLE;
          end else begin
            mem_req_addr_d  = alu_d;
            mem_req_wdata_d = s2_q;
            mem_req_we_d    = is_st_q;
            state_d         = MEM_REQ;
          end
        end else begin
          alu_op = op_q;
          alu_s1 = s1_q;
          alu_s2 = s2_q;
          if (!flush) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_d;
          end
          state_d = IDLE;
        end
      end
      BR_TGT: begin
        alu_op = OP_ADD;
        alu_s1 = pc_q;
        alu_s2 = imm_q;
        if (!flush) begin
          br_valid_d  = 1'b1;
          br_taken_d  = 1'b1;
          br_target_d = {alu_d[REG_DATA_WIDTH-1:1], 1'b0};
        end
        state_d = IDLE;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (flush) kill_d = 1'b1;
        if (mem_req_ready) state_d = mem_req_we_q ? IDLE : MEM_RSP;
      end
      MEM_RSP: begin
        if (flush) kill_d = 1'b1;
        if (mem_rsp_valid) begin
          if (!(kill_q || flush)) begin
            wb_valid_d = 1'b1;
            wb_data_d  = mem_rsp_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      op_q            <= '0;
      s1_q            <= '0;
      s2_q            <= '0;
      imm_q           <= '0;
      pc_q            <= '0;
      is_br_q         <= 1'b0;
      is_ls_q         <= 1'b0;
      is_st_q         <= 1'b0;
      kill_q          <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_data_q       <= '0;
      br_valid_q      <= 1'b0;
      br_taken_q      <= 1'b0;
      br_target_q     <= '0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_we_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      imm_q           <= imm_d;
      pc_q            <= pc_d;
      is_br_q         <= is_br_d;
      is_ls_q         <= is_ls_d;
      is_st_q         <= is_st_d;
      kill_q          <= kill_d;
      wb_valid_q      <= wb_valid_d;
      wb_data_q       <= wb_data_d;
      br_valid_q      <= br_valid_d;
      br_taken_q      <= br_taken_d;
      br_target_q     <= br_target_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      mem_req_we_q    <= mem_req_we_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign br_valid      = br_valid_q;
  assign br_taken      = br_taken_q;
  assign br_target     = br_target_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_we    = mem_req_we_q;

endmodule

// File: doc/core_exec_sequencer.md
# core_exec_sequencer

Multi-cycle controller that sequences the core's single shared execution unit (ALU) for every issued instruction. It accepts one instruction per valid/ready handshake and drives the ALU operands and op. For branches it reuses the ALU over two cycles: compare, then target add. For loads and stores it computes the effective address on the ALU, then runs the data-memory request/response handshake. It sits between decode/issue and the execution unit, writeback and fetch redirect.

## Interface
- REG_DATA_WIDTH, 32, operand/result width
- ALU_OP_WIDTH, 4, ALU opcode width
- ALU_OP_ADD, 0, ALU opcode the sequencer forces for address and target additions
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- issue_valid / issue_ready  in / out  1 / 1  instruction handshake
- issue_alu_op  in  ALU_OP_WIDTH  op for the EXEC cycle (branch compare op for branches)
- issue_s1, issue_s2, issue_imm, issue_pc  in  REG_DATA_WIDTH  operands, immediate, instruction PC
- issue_is_branch, issue_is_loadstore, issue_is_store  in  1  class flags
- flush  in  1  kill current instruction (see Operation)
- alu_op  out  ALU_OP_WIDTH  to execution unit
- alu_s1, alu_s2  out  REG_DATA_WIDTH  to execution unit
- alu_d  in  REG_DATA_WIDTH  combinational ALU result
- mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake
- mem_req_addr, mem_req_wdata  out  REG_DATA_WIDTH  address, store data
- mem_req_we  out  1  1 = store
- mem_rsp_valid  in  1  load data valid
- mem_rsp_rdata  in  REG_DATA_WIDTH  load data
- wb_valid  out  1  one-cycle writeback pulse
- wb_data  out  REG_DATA_WIDTH  writeback value
- br_valid  out  1  one-cycle branch-resolve pulse
- br_taken  out  1  branch outcome
- br_target  out  REG_DATA_WIDTH  branch target, bit 0 cleared

## Operation
- States: IDLE, EXEC, BR_TGT, MEM_REQ, MEM_RSP.
- IDLE: issue_ready=1. On issue_valid, latch all issue_* inputs and go to EXEC. issue_ready=0 in every other state.
- Class priority: is_branch over is_loadstore over plain ALU.
- EXEC, plain ALU: alu_op/s1/s2 = latched op/s1/s2. Register alu_d into wb_data, pulse wb_valid next cycle, then IDLE.
- EXEC, branch: latched compare op on s1/s2; taken = alu_d[0].
  - Taken: go to BR_TGT.
  - Not taken: next cycle pulse br_valid with br_taken=0, br_target=0, then IDLE.
- BR_TGT: alu_op=ALU_OP_ADD, s1=pc, s2=imm. Next cycle pulse br_valid with br_taken=1 and br_target = alu_d with bit 0 cleared, then IDLE.
- EXEC, loadstore: alu_op=ALU_OP_ADD, s1=s1, s2=imm. Register result into mem_req_addr and set mem_req_wdata=s2; go to MEM_REQ.
- MEM_REQ: mem_req_valid=1. addr, wdata and we stay stable until mem_req_ready (no retraction).
  - Store accepted: go to IDLE; no wb_valid.
  - Load accepted: go to MEM_RSP.
- MEM_RSP: wait for mem_rsp_valid, then register rdata into wb_data, pulse wb_valid next cycle, then IDLE.
- Outside their active states, ALU outputs are 0 and mem_req_valid=0.
- Flush:
  - In EXEC or BR_TGT: return to IDLE next cycle; no wb_valid, no br_valid.
  - In MEM_REQ/MEM_RSP: the transaction completes normally, but a pending load's wb_valid is suppressed.
  - In IDLE: a simultaneous issue_valid is not accepted.

## Timing
- Reset values: state=IDLE, issue_ready=0 during reset (1 from the first cycle after release), mem_req_valid=0, wb_valid=0, br_valid=0, br_taken=0, and all data outputs 0.
- Reset mid-operation abandons everything, including an outstanding memory request, with no pulses.
- Issue accepted in cycle 0 gives the following latencies:
  - ALU op: wb_valid in cycle 2.
  - Branch not taken: br_valid in cycle 2.
  - Branch taken: br_valid in cycle 3.
  - Store, mem_req_ready in cycle 2: back in IDLE in cycle 3.
  - Load, mem_req_ready in cycle 2 and mem_rsp_valid in cycle k: wb_valid in cycle k+1.
- Next issue can be accepted in the same cycle that wb_valid or br_valid pulses (state already IDLE). Peak throughput is one ALU op per 2 cycles.
- Additions wrap modulo 2^REG_DATA_WIDTH; no overflow flag.
- mem_rsp_valid outside MEM_RSP is ignored.

## Test plan
- ALU op, s1=5, s2=7, alu model adds -> alu_s1=5/alu_s2=7 in cycle 1; wb_valid=1, wb_data=12 in cycle 2; issue_ready=0 in cycle 1, 1 in cycle 2.
- Taken branch, compare returns 1, pc=0x100, imm=0x21 -> BR_TGT drives ADD 0x100+0x21; br_valid in cycle 3 with br_taken=1, br_target=0x120. Not-taken variant: br_valid in cycle 2 with br_taken=0.
- Load, s1=0xFFFFFFFC, imm=8, mem_req_ready low for 3 cycles -> mem_req_addr=0x4 (wrap) held stable with mem_req_valid=1 for 4 cycles, mem_req_we=0. rdata=0xDEADBEEF in cycle 9 -> wb_valid, wb_data=0xDEADBEEF in cycle 10.
- Store, s2=0xA5 -> mem_req_we=1, wdata=0xA5; no wb_valid after acceptance; issue_ready=1 the next cycle.
- Flush in EXEC of an ALU op gives no wb_valid. Flush in MEM_RSP of a load: response is consumed, wb_valid suppressed, then IDLE.
- rst_n low for 1 cycle while in MEM_REQ -> next cycle all outputs are at reset values and state is IDLE; mem_rsp_valid arriving afterwards causes no wb_valid.
